// File: rtl/lcd_string_writer.sv
// Streams a NUL-terminated string from a synchronous character ROM to the LCD
// controller, one character per write handshake, started by a rising edge of I_START.
module lcd_string_writer #(
  parameter int SEL_W = 2,
  parameter int IDX_W = 4
) (
  input  logic                   I_CLK,
  input  logic                   I_RST,
  input  logic                   I_INIT_DONE,
  input  logic                   I_START,
  input  logic [SEL_W-1:0]       I_MSG_SEL,
  output logic [SEL_W+IDX_W-1:0] O_CHAR_ADDR,
  input  logic [7:0]             I_CHAR_DATA,
  output logic [7:0]             O_DISPLAY_DATA,
  output logic                   O_WRITE_START,
  input  logic                   I_WRITE_DONE,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  output logic [IDX_W:0]         O_CHAR_COUNT
);

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    FETCH,
    LATCH,
    WRITE,
    WAIT_DONE,
    FINISH
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t           state_reg, state_next;
  logic             start_q_reg;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       data_reg, data_next;
  logic [IDX_W:0]   cnt_reg, cnt_next;
  logic [IDX_W:0]   count_reg, count_next;
  logic             start_edge;

  assign start_edge = I_START & ~start_q_reg;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_reg   <= WAIT_INIT;
      start_q_reg <= 1'b0;
      sel_reg     <= '0;
      idx_reg     <= '0;
      data_reg    <= 8'h00;
      cnt_reg     <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      start_q_reg <= I_START;
      sel_reg     <= sel_next;
      idx_reg     <= idx_next;
      data_reg    <= data_next;
      cnt_reg     <= cnt_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    count_next = count_reg;
    case (state_reg)
      WAIT_INIT: if (I_INIT_DONE) state_next = IDLE;
      IDLE: begin
        if (start_edge) begin
          sel_next   = I_MSG_SEL;
          idx_next   = '0;
          cnt_next   = '0;
          state_next = FETCH;
        end
      end
      FETCH: state_next = LATCH;
      LATCH: begin
        if (I_CHAR_DATA == 8'h00) begin
          state_next = FINISH;
        end else begin
          data_next  = I_CHAR_DATA;
          state_next = WRITE;
        end
      end
      // The write-done input is deliberately not looked at during the strobe cycle.
      WRITE: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (I_WRITE_DONE) begin
          cnt_next = cnt_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = FINISH;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end
      FINISH: begin
        count_next = cnt_reg;
        state_next = IDLE;
      end
      default: state_next = WAIT_INIT;
    endcase
  end

  assign O_CHAR_ADDR    = {sel_reg, idx_reg};
  assign O_DISPLAY_DATA = data_reg;
  assign O_WRITE_START  = (state_reg == WRITE);
  assign O_DONE         = (state_reg == FINISH);
  assign O_BUSY         = (state_reg != WAIT_INIT) && (state_reg != IDLE);
  assign O_CHAR_COUNT   = count_reg;

endmodule

// File: tb/tb_lcd_string_writer.sv
// Bench for lcd_string_writer: ROM model, write-done responder and a scoreboard
// of expected characters checked on every write strobe.
module tb_lcd_string_writer;
  localparam int SEL_W = 2;
  localparam int IDX_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   init_done;
  logic                   start;
  logic [SEL_W-1:0]       msg_sel;
  logic [SEL_W+IDX_W-1:0] char_addr;
  logic [7:0]             char_data;
  logic [7:0]             display_data;
  logic                   write_start;
  logic                   write_done;
  logic                   busy;
  logic                   done;
  logic [IDX_W:0]         char_count;

  lcd_string_writer #(.SEL_W(SEL_W), .IDX_W(IDX_W)) dut (
    .I_CLK(clk), .I_RST(rst), .I_INIT_DONE(init_done), .I_START(start),
    .I_MSG_SEL(msg_sel), .O_CHAR_ADDR(char_addr), .I_CHAR_DATA(char_data),
    .O_DISPLAY_DATA(display_data), .O_WRITE_START(write_start),
    .I_WRITE_DONE(write_done), .O_BUSY(busy), .O_DONE(done), .O_CHAR_COUNT(char_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  logic prev_ws = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rom [0:63];

  always @(posedge clk) char_data <= rom[char_addr];

  // Responder: answers each strobe after wd_delay cycles, holding done for wd_hold cycles.
  int wd_delay = 5;
  int wd_hold = 1;
  int cd = 0;
  int hl = 0;
  always @(negedge clk) begin
    if (rst) begin
      cd = 0; hl = 0; write_done = 1'b0;
    end else begin
      if (write_start) cd = wd_delay;
      else if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) hl = wd_hold;
      end
      if (hl > 0) begin write_done = 1'b1; hl = hl - 1; end
      else write_done = 1'b0;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cyc = busy_cyc + 1;
      if (prev_ws) begin
        total = total + 1;
        if (write_start !== 1'b0) begin
          bad = bad + 1;
          $display("FAIL strobe_width: write_start=%b required 0", write_start);
        end
      end
      if (write_start) begin
        strobe_cnt = strobe_cnt + 1;
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_strobe: data=%h required no strobe", display_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("write char %h (expected %h)", display_data, e);
          if (display_data !== e) begin
            bad = bad + 1;
            $display("FAIL char_data: got %h required %h", display_data, e);
          end
        end
      end
      if (done) done_cnt = done_cnt + 1;
    end
    prev_ws = write_start;
  end

  task automatic push_msg(input int sel);
    for (int i = 0; i < 16; i++) begin
      if (rom[sel*16+i] == 8'h00) break;
      exp_q.push_back(rom[sel*16+i]);
    end
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    msg_sel = sel[SEL_W-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (strobe_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic clear_counts();
    strobe_cnt = 0; done_cnt = 0; busy_cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_done = 1'b0; start = 1'b0; msg_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total = total + 6;
    if (write_start !== 1'b0) begin bad++; $display("FAIL reset_ws: got %b required 0", write_start); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done); end
    if (char_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h required 0", char_addr); end
    if (display_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h required 00", display_data); end
    if (char_count !== '0) begin bad++; $display("FAIL reset_count: got %0d required 0", char_count); end
    rst = 1'b0;
    clear_counts();
    for (int i = 0; i < 4; i++) pulse_start(1);
    repeat (8) @(negedge clk);
    total = total + 2;
    if (strobe_cnt != 0) begin bad++; $display("FAIL no_init_strobe: got %0d required 0", strobe_cnt); end
    if (busy_cyc != 0) begin bad++; $display("FAIL no_init_busy: got %0d required 0", busy_cyc); end
  endtask

  task automatic test_hello();
    bit ok;
    init_done = 1'b1;
    wd_delay = 5; wd_hold = 1;
    repeat (2) @(negedge clk);
    clear_counts();
    push_msg(1);
    msg_sel = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total = total + 4;
    if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy: got %b required 1", busy); end
    if (write_start !== 1'b0) begin bad++; $display("FAIL lat_k1: got %b required 0", write_start); end
    @(negedge clk);
    if (write_start !== 1'b0) begin bad++; $display("FAIL lat_k2: got %b required 0", write_start); end
    @(negedge clk);
    if (write_start !== 1'b1) begin bad++; $display("FAIL lat_k3: got %b required 1", write_start); end
    wait_done(200, ok);
    repeat (2) @(negedge clk);
    total = total + 6;
    if (!ok) begin bad++; $display("FAIL hello_timeout: got no done required done"); end
    if (strobe_cnt != 5) begin bad++; $display("FAIL hello_strobes: got %0d required 5", strobe_cnt); end
    if (done_cnt != 1) begin bad++; $display("FAIL hello_done: got %0d required 1", done_cnt); end
    if (char_count !== 5) begin bad++; $display("FAIL hello_count: got %0d required 5", char_count); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL hello_left: got %0d required 0", exp_q.size()); end
    if (busy !== 1'b0) begin bad++; $display("FAIL hello_busy: got %b required 0", busy); end
  endtask

  task automatic test_full_length();
    bit ok;
    wd_delay = 2; wd_hold = 1;
    clear_counts();
    push_msg(2);
    pulse_start(2);
    wait_done(400, ok);
    repeat (6) @(negedge clk);
    total = total + 5;
    if (!ok) begin bad++; $display("FAIL full_timeout: got no done required done"); end
    if (strobe_cnt != 16) begin bad++; $display("FAIL full_strobes: got %0d required 16", strobe_cnt); end
    if (char_count !== 16) begin bad++; $display("FAIL full_count: got %0d required 16", char_count); end
    if (done_cnt != 1) begin bad++; $display("FAIL full_done: got %0d required 1", done_cnt); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL full_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_empty();
    bit ok;
    clear_counts();
    pulse_start(3);
    wait_done(50, ok);
    repeat (4) @(negedge clk);
    total = total + 5;
    if (!ok) begin bad++; $display("FAIL empty_timeout: got no done required done"); end
    if (strobe_cnt != 0) begin bad++; $display("FAIL empty_strobes: got %0d required 0", strobe_cnt); end
    if (done_cnt != 1) begin bad++; $display("FAIL empty_done: got %0d required 1", done_cnt); end
    if (char_count !== 0) begin bad++; $display("FAIL empty_count: got %0d required 0", char_count); end
    if (busy_cyc != 3) begin bad++; $display("FAIL empty_busy: got %0d required 3", busy_cyc); end
  endtask

  task automatic test_ignored();
    bit ok;
    wd_delay = 5; wd_hold = 4;
    clear_counts();
    push_msg(1);
    pulse_start(1);
    wait_strobes(2, 100, ok);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300, ok);
    repeat (10) @(negedge clk);
    total = total + 5;
    if (!ok) begin bad++; $display("FAIL ign_timeout: got no done required done"); end
    if (strobe_cnt != 5) begin bad++; $display("FAIL ign_strobes: got %0d required 5", strobe_cnt); end
    if (char_count !== 5) begin bad++; $display("FAIL ign_count: got %0d required 5", char_count); end
    if (done_cnt != 1) begin bad++; $display("FAIL ign_done: got %0d required 1", done_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wd_delay = 3; wd_hold = 1;
    clear_counts();
    push_msg(1);
    pulse_start(1);
    wait_done(200, ok);
    // This posedge moved FINISH to IDLE; the next negedge is inside the first IDLE cycle.
    push_msg(0);
    @(negedge clk);
    msg_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    total = total + 5;
    if (!ok) begin bad++; $display("FAIL b2b_timeout: got no done required done"); end
    if (strobe_cnt != 7) begin bad++; $display("FAIL b2b_strobes: got %0d required 7", strobe_cnt); end
    if (done_cnt != 2) begin bad++; $display("FAIL b2b_done: got %0d required 2", done_cnt); end
    if (char_count !== 2) begin bad++; $display("FAIL b2b_count: got %0d required 2", char_count); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    wd_delay = 5; wd_hold = 1;
    clear_counts();
    push_msg(1);
    pulse_start(1);
    wait_strobes(3, 100, ok);
    @(negedge clk);
    rst = 1'b1;
    init_done = 1'b0;
    @(negedge clk);
    total = total + 7;
    if (!ok) begin bad++; $display("FAIL mr_timeout: got %0d strobes required 3", strobe_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy: got %b required 0", busy); end
    if (write_start !== 1'b0) begin bad++; $display("FAIL mr_ws: got %b required 0", write_start); end
    if (done !== 1'b0) begin bad++; $display("FAIL mr_done: got %b required 0", done); end
    if (char_addr !== '0) begin bad++; $display("FAIL mr_addr: got %h required 0", char_addr); end
    if (display_data !== 8'h00) begin bad++; $display("FAIL mr_data: got %h required 00", display_data); end
    if (char_count !== '0) begin bad++; $display("FAIL mr_count: got %0d required 0", char_count); end
    rst = 1'b0;
    exp_q.delete();
    pulse_start(1);
    repeat (20) @(negedge clk);
    total = total + 3;
    if (strobe_cnt != 3) begin bad++; $display("FAIL mr_strobes: got %0d required 3", strobe_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mr_wait_init: got busy %b required 0", busy); end
    if (done_cnt != 0) begin bad++; $display("FAIL mr_no_done: got %0d required 0", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[0] = "A"; rom[1] = "B";
    rom[16] = 8'h48; rom[17] = 8'h45; rom[18] = 8'h4C; rom[19] = 8'h4C; rom[20] = 8'h4F;
    for (int i = 0; i < 16; i++) rom[32+i] = 8'h41 + 8'(i);
    rom[48] = 8'h00; rom[49] = "Z";
    test_reset();
    test_hello();
    test_full_length();
    test_empty();
    test_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
